uart_rx_fifo_core: RTL and testbench

//  Parametrised UART receiver with oversampled start/majority-vote sampling, parity/framing check
//  and buffered output. Replaces the stub receiver under uart_dut; feeds REG_RX_DATA/REG_STATUS.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_rx_fifo_core.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo_core.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART receive path.
// Parity modes, FSM states, RX FIFO entry layout, vote helper.
package uart_pkg;

   // Storage width of the entry data field; top MAX_DATA_W must not exceed it.
   localparam int UART_DATA_W = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   typedef struct packed {
      logic                   brk;
      logic                   perr;
      logic                   ferr;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO of rx_entry_t with occupancy level.
// Ports: clk, rst_n, push/wr_entry, pop/rd_entry, empty, full, level.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rx_entry_t                wr_entry,
   input  logic                     pop,
   output rx_entry_t                rd_entry,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   rx_entry_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign empty = (level == '0);
   assign full  = (level == (AW+1)'(DEPTH));

   // A push into a full FIFO is still taken when a pop frees the slot.
   assign wr_ok = push && (!full || pop);
   assign rd_ok = pop && !empty;

   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_ok, rd_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo_core.sv
// uart_rx_fifo_core: oversampling UART receiver feeding an RX FIFO.
// Ports: clk, rst_n, rx, rx_en, baud_div, cfg_data_bits, cfg_stop_bits,
//   cfg_parity, rd_data/rd_err/rd_valid/rd_ready (pop port), fifo_level,
//   overrun, err_clr, rx_busy, break_det.
// Option: define UART_RX_BREAK_DET_EN to enable break detection.
module uart_rx_fifo_core
   import uart_pkg::*;
#(
   parameter int MAX_DATA_W = UART_DATA_W,
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   input  logic                          rx_en,
   input  logic [15:0]                   baud_div,
   input  logic [$clog2(MAX_DATA_W)-1:0] cfg_data_bits,
   input  logic                          cfg_stop_bits,
   input  logic [1:0]                    cfg_parity,
   output logic [MAX_DATA_W-1:0]         rd_data,
   output logic [2:0]                    rd_err,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   input  logic                          err_clr,
   output logic                          rx_busy,
   output logic                          break_det
);

   localparam int DBW = $clog2(MAX_DATA_W);
   localparam int OW  = $clog2(OVERSAMPLE);

   localparam logic [OW-1:0]  T_A   = OW'(OVERSAMPLE/2 - 1);
   localparam logic [OW-1:0]  T_B   = OW'(OVERSAMPLE/2);
   localparam logic [OW-1:0]  T_C   = OW'(OVERSAMPLE/2 + 1);
   localparam logic [OW-1:0]  T_END = OW'(OVERSAMPLE - 1);
   localparam logic [DBW-1:0] D_MAX = DBW'(MAX_DATA_W - 1);

   rx_state_e              st;
   rx_state_e              st_nx;
   logic [1:0]             sync_q;
   logic                   rxs;
   logic                   armed_q;
   logic [15:0]            tick_cnt;
   logic                   tick;
   logic [OW-1:0]          os_cnt;
   logic                   s_a;
   logic                   s_b;
   logic                   maj;
   logic                   smp_a;
   logic                   smp_b;
   logic                   dec;
   logic                   bit_end;
   logic [DBW-1:0]         bit_idx;
   logic [DBW-1:0]         nbits_m1;
   logic                   last_bit;
   logic [MAX_DATA_W-1:0]  data_q;
   logic                   par_q;
   logic                   par_en;
   logic                   par_odd;
   logic                   perr;
   logic                   brk;
   logic                   restart;
   logic                   push_req;
   logic                   ovr_set;
   logic                   fifo_empty;
   logic                   fifo_full;
   rx_entry_t              wr_entry;
   rx_entry_t              head;

   // The second stop bit is plain idle-high line time: the frame is
   // pushed at the first stop decision either way.
   logic                   cfg_unused;
   assign cfg_unused = cfg_stop_bits;

   assign rxs = sync_q[1];

   assign tick    = (tick_cnt == baud_div);
   assign smp_a   = tick && (os_cnt == T_A);
   assign smp_b   = tick && (os_cnt == T_B);
   assign dec     = tick && (os_cnt == T_C);
   assign bit_end = tick && (os_cnt == T_END);
   assign maj     = maj3(s_a, s_b, rxs);

   assign nbits_m1 = (cfg_data_bits > D_MAX) ? D_MAX : cfg_data_bits;
   assign last_bit = (bit_idx == nbits_m1);

   assign par_en  = (cfg_parity != PAR_NONE);
   assign par_odd = (cfg_parity == PAR_ODD);
   assign perr    = par_en && ((^data_q ^ par_q) != par_odd);

   assign rx_busy = (st != ST_IDLE);

   always_comb begin
      st_nx    = st;
      push_req = 1'b0;
      restart  = 1'b0;
      unique case (st)
         ST_IDLE: begin
            if (rx_en && armed_q && !rxs) begin
               st_nx   = ST_START;
               restart = 1'b1;
            end
         end
         ST_START: begin
            if (dec && maj)   st_nx = ST_IDLE;
            else if (bit_end) st_nx = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && last_bit)
               st_nx = par_en ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (bit_end) st_nx = ST_STOP;
         end
         ST_STOP: begin
            if (dec) begin
               st_nx    = ST_IDLE;
               push_req = 1'b1;
            end
         end
         default: st_nx = ST_IDLE;
      endcase
      if ((st != ST_IDLE) && !rx_en) begin
         st_nx    = ST_IDLE;
         push_req = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= ST_IDLE;
      else        st <= st_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= 2'b11;
         armed_q  <= 1'b0;
         tick_cnt <= '0;
         os_cnt   <= '0;
         s_a      <= 1'b0;
         s_b      <= 1'b0;
         bit_idx  <= '0;
         data_q   <= '0;
         par_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rx};
         // Start needs rx seen high in IDLE first: a falling edge, and
         // no re-trigger on a line still low after a bad stop bit.
         armed_q <= (st == ST_IDLE) ? rxs : 1'b0;
         if (restart || tick) tick_cnt <= '0;
         else                 tick_cnt <= tick_cnt + 16'd1;
         if (restart) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
         end else begin
            if (tick)
               os_cnt <= (os_cnt == T_END) ? '0 : os_cnt + OW'(1);
            if (dec && (st == ST_DATA))   data_q[bit_idx] <= maj;
            if (dec && (st == ST_PARITY)) par_q <= maj;
            if (bit_end && (st == ST_DATA)) bit_idx <= bit_idx + DBW'(1);
         end
         if (smp_a) s_a <= rxs;
         if (smp_b) s_b <= rxs;
      end
   end

`ifdef UART_RX_BREAK_DET_EN
   assign brk = ~|data_q && !(par_en && par_q) && !maj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                break_det <= 1'b0;
      else if (push_req && brk)  break_det <= 1'b1;
      else if (err_clr)          break_det <= 1'b0;
   end
`else
   assign brk       = 1'b0;
   assign break_det = 1'b0;
`endif

   always_comb begin
      wr_entry      = '0;
      wr_entry.brk  = brk;
      wr_entry.perr = perr;
      wr_entry.ferr = !maj;
      wr_entry.data = UART_DATA_W'(data_q);
   end

   // Full with a pop in the same cycle still accepts the push.
   assign ovr_set = push_req && fifo_full && !rd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_req),
      .wr_entry (wr_entry),
      .pop      (rd_ready),
      .rd_entry (head),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .level    (fifo_level)
   );

   // Gate the head so an empty FIFO shows zeros, not stale storage.
   assign rd_valid = !fifo_empty;
   assign rd_data  = rd_valid ? MAX_DATA_W'(head.data) : '0;
   assign rd_err   = rd_valid ? {head.brk, head.perr, head.ferr} : 3'b000;

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// tb_uart_rx_fifo_core: directed bench for uart_rx_fifo_core.
// baud_div=3 -> 4 clk per tick, 64 clk per bit.
module tb_uart_rx_fifo_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        rx_en = 1'b0;
   logic [15:0] baud_div = 16'd3;
   logic [3:0]  cfg_data_bits = 4'd7;
   logic        cfg_stop_bits = 1'b0;
   logic [1:0]  cfg_parity = 2'b00;
   logic [8:0]  rd_data;
   logic [2:0]  rd_err;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [4:0]  fifo_level;
   logic        overrun;
   logic        err_clr = 1'b0;
   logic        rx_busy;
   logic        break_det;

   int pass_cnt = 0;
   int chk_cnt = 0;

`ifdef UART_RX_BREAK_DET_EN
   localparam logic [2:0] BRK_ERR = 3'b101;
   localparam logic       BRK_DET = 1'b1;
`else
   localparam logic [2:0] BRK_ERR = 3'b001;
   localparam logic       BRK_DET = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_rx_fifo_core dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .rx_en         (rx_en),
      .baud_div      (baud_div),
      .cfg_data_bits (cfg_data_bits),
      .cfg_stop_bits (cfg_stop_bits),
      .cfg_parity    (cfg_parity),
      .rd_data       (rd_data),
      .rd_err        (rd_err),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .fifo_level    (fifo_level),
      .overrun       (overrun),
      .err_clr       (err_clr),
      .rx_busy       (rx_busy),
      .break_det     (break_det)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic send_bits(input logic [15:0] bits, input int n);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         rx = bits[i];
         repeat (64) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (64 * n) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk) rd_ready = 1'b1;
      @(negedge clk) rd_ready = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!rd_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if (!rd_valid) $display("FAIL %s timeout rd_valid=%b exp=1", name, rd_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({rd_valid, rx_busy, overrun, break_det} !== 4'b0000)
         $display("FAIL reset_flags got=%b exp=0000",
                  {rd_valid, rx_busy, overrun, break_det});
      else pass_cnt++;
      chk_cnt++;
      if (fifo_level !== 5'd0 || rd_data !== 9'd0 || rd_err !== 3'd0)
         $display("FAIL reset_data lvl=%0d data=%h err=%b exp=0",
                  fifo_level, rd_data, rd_err);
      else pass_cnt++;
      rst_n = 1'b1;
      rx_en = 1'b1;
      idle_bits(1);
   endtask

   task automatic test_8n1();
      cfg_data_bits = 4'd7;
      cfg_parity = 2'b00;
      fork
         send_bits({6'b111111, 1'b1, 8'hA5, 1'b0}, 10);
         begin
            @(negedge clk);
            repeat (618) @(posedge clk);
            #1;
            chk_cnt++;
            if (rd_valid !== 1'b0) $display("FAIL 8n1_early got=%b exp=0", rd_valid);
            else pass_cnt++;
            @(posedge clk);
            #1;
            chk_cnt++;
            if (rd_valid !== 1'b1) $display("FAIL 8n1_latency got=%b exp=1", rd_valid);
            else pass_cnt++;
         end
      join
      chk_cnt++;
      if (rd_data !== 9'h0A5 || rd_err !== 3'b000)
         $display("FAIL 8n1_entry data=%h err=%b exp=0a5/000", rd_data, rd_err);
      else pass_cnt++;
      pop_one();
      chk_cnt++;
      if (fifo_level !== 5'd0) $display("FAIL 8n1_pop lvl=%0d exp=0", fifo_level);
      else pass_cnt++;
   endtask

   task automatic test_parity();
      cfg_parity = 2'b01;
      // 0x3C has four ones: odd parity needs p=1, so p=0 is wrong.
      send_bits({5'b11111, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
      wait_valid("odd_bad");
      chk_cnt++;
      if (rd_data !== 9'h03C || rd_err !== 3'b010)
         $display("FAIL odd_bad data=%h err=%b exp=03c/010", rd_data, rd_err);
      else pass_cnt++;
      pop_one();
      send_bits({5'b11111, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
      wait_valid("odd_good");
      chk_cnt++;
      if (rd_data !== 9'h03C || rd_err !== 3'b000)
         $display("FAIL odd_good data=%h err=%b exp=03c/000", rd_data, rd_err);
      else pass_cnt++;
      pop_one();
      cfg_parity = 2'b00;
   endtask

   task automatic test_clamp();
      cfg_data_bits = 4'd15;
      send_bits({5'b11111, 1'b1, 9'h155, 1'b0}, 11);
      wait_valid("clamp");
      chk_cnt++;
      if (rd_data !== 9'h155 || rd_err !== 3'b000)
         $display("FAIL clamp data=%h err=%b exp=155/000", rd_data, rd_err);
      else pass_cnt++;
      pop_one();
      cfg_data_bits = 4'd7;
   endtask

   task automatic test_false_start();
      @(negedge clk) rx = 1'b0;
      repeat (12) @(negedge clk);
      chk_cnt++;
      if (rx_busy !== 1'b1) $display("FAIL fstart_busy got=%b exp=1", rx_busy);
      else pass_cnt++;
      rx = 1'b1;
      repeat (100) @(negedge clk);
      chk_cnt++;
      if (rx_busy !== 1'b0) $display("FAIL fstart_idle got=%b exp=0", rx_busy);
      else pass_cnt++;
      chk_cnt++;
      if (fifo_level !== 5'd0 || rd_valid !== 1'b0)
         $display("FAIL fstart_nopush lvl=%0d valid=%b exp=0/0", fifo_level, rd_valid);
      else pass_cnt++;
   endtask

   task automatic test_frame_err();
      cfg_data_bits = 4'd8;
      cfg_parity = 2'b10;
      cfg_stop_bits = 1'b1;
      // 0x1FF has nine ones: even parity p=1; stop 0, line held low.
      send_bits({3'b000, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b0}, 13);
      chk_cnt++;
      if (rx_busy !== 1'b0) $display("FAIL ferr_rearm busy=%b exp=0", rx_busy);
      else pass_cnt++;
      chk_cnt++;
      if (fifo_level !== 5'd1 || rd_data !== 9'h1FF || rd_err !== 3'b001)
         $display("FAIL ferr_entry lvl=%0d data=%h err=%b exp=1/1ff/001",
                  fifo_level, rd_data, rd_err);
      else pass_cnt++;
      pop_one();
      idle_bits(1);
      send_bits({3'b111, 1'b1, 1'b1, 1'b1, 9'h100, 1'b0}, 13);
      wait_valid("9e2_good");
      chk_cnt++;
      if (rd_data !== 9'h100 || rd_err !== 3'b000)
         $display("FAIL 9e2_good data=%h err=%b exp=100/000", rd_data, rd_err);
      else pass_cnt++;
      pop_one();
      cfg_data_bits = 4'd7;
      cfg_parity = 2'b00;
      cfg_stop_bits = 1'b0;
   endtask

   task automatic test_break();
      send_bits(16'h0000, 12);
      wait_valid("break");
      chk_cnt++;
      if (rd_data !== 9'h000 || rd_err !== BRK_ERR)
         $display("FAIL break_entry data=%h err=%b exp=000/%b", rd_data, rd_err, BRK_ERR);
      else pass_cnt++;
      chk_cnt++;
      if (break_det !== BRK_DET)
         $display("FAIL break_det got=%b exp=%b", break_det, BRK_DET);
      else pass_cnt++;
      pop_one();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      chk_cnt++;
      if (break_det !== 1'b0) $display("FAIL break_clr got=%b exp=0", break_det);
      else pass_cnt++;
      idle_bits(1);
   endtask

   task automatic test_overrun();
      int n = 0;
      int bad = 0;
      for (int k = 0; k < 17; k++) begin
         send_bits({6'b111111, 1'b1, 8'h55, 1'b0}, 10);
         idle_bits(1);
         if (k == 15) begin
            chk_cnt++;
            if (fifo_level !== 5'd16 || overrun !== 1'b0)
               $display("FAIL ovr_16 lvl=%0d ovr=%b exp=16/0", fifo_level, overrun);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (fifo_level !== 5'd16 || overrun !== 1'b1)
         $display("FAIL ovr_17 lvl=%0d ovr=%b exp=16/1", fifo_level, overrun);
      else pass_cnt++;
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      chk_cnt++;
      if (overrun !== 1'b0) $display("FAIL ovr_clr got=%b exp=0", overrun);
      else pass_cnt++;
      while (rd_valid && n < 40) begin
         if (rd_data !== 9'h055 || rd_err !== 3'b000) bad++;
         pop_one();
         n++;
      end
      chk_cnt++;
      if (n !== 16) $display("FAIL ovr_drain popped=%0d exp=16", n);
      else pass_cnt++;
      chk_cnt++;
      if (bad !== 0) $display("FAIL ovr_data bad_entries=%0d exp=0", bad);
      else pass_cnt++;
   endtask

   task automatic test_pop_empty();
      @(negedge clk) rd_ready = 1'b1;
      repeat (2) @(negedge clk);
      rd_ready = 1'b0;
      chk_cnt++;
      if (fifo_level !== 5'd0 || rd_valid !== 1'b0)
         $display("FAIL pop_empty lvl=%0d valid=%b exp=0/0", fifo_level, rd_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      send_bits({6'b111111, 1'b1, 8'hC3, 1'b0}, 10);
      idle_bits(1);
      send_bits({13'h1FFF, 3'b010}, 3);
      rx = 1'b0;
      repeat (10) @(negedge clk);
      chk_cnt++;
      if (rx_busy !== 1'b1 || fifo_level !== 5'd1)
         $display("FAIL mid_pre busy=%b lvl=%0d exp=1/1", rx_busy, fifo_level);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({rd_valid, rx_busy, overrun, break_det} !== 4'b0000 ||
          fifo_level !== 5'd0 || rd_data !== 9'd0 || rd_err !== 3'd0)
         $display("FAIL mid_reset flags=%b lvl=%0d data=%h err=%b exp=0",
                  {rd_valid, rx_busy, overrun, break_det}, fifo_level, rd_data, rd_err);
      else pass_cnt++;
      rx = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      idle_bits(1);
      send_bits({6'b111111, 1'b1, 8'h12, 1'b0}, 10);
      wait_valid("post_reset");
      chk_cnt++;
      if (rd_data !== 9'h012 || rd_err !== 3'b000 || fifo_level !== 5'd1)
         $display("FAIL post_reset data=%h err=%b lvl=%0d exp=012/000/1",
                  rd_data, rd_err, fifo_level);
      else pass_cnt++;
      pop_one();
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_clamp();
      test_false_start();
      test_frame_err();
      test_break();
      test_overrun();
      test_pop_empty();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
